uart_dbg_bridge: RTL and testbench
==================================

UART_DBG_BRIDGE -- requirements
Module: uart_dbg_bridge

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024, the number of idle cycles allowed between bytes of one frame.
REQ-002 SHALL have parameter CmdRead, default 8'h11, the read command byte.
REQ-003 SHALL have parameter CmdWrite, default 8'h12, the write command byte.
REQ-004 SHALL have parameter RspAck, default 8'h06, the success response byte.
REQ-005 SHALL have parameter RspNak, default 8'h15, the bus-error response byte.
REQ-006 One clock; reset is asynchronous and active-low. Ports SHALL be listed clock and reset first:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
REQ-007 SHALL have the UART RX byte-stream ports rx_valid_i (in, 1), rx_data_i (in, 8) and rx_ready_o (out, 1).
REQ-008 SHALL have the UART TX byte-stream ports tx_valid_o (out, 1), tx_data_o (out, 8) and tx_ready_i (in, 1).
REQ-009 SHALL have the OBI manager request ports obi_req_o (out, 1), obi_gnt_i (in, 1), obi_addr_o (out, 32), obi_we_o (out, 1), obi_be_o (out, 4) and obi_wdata_o (out, 32).
REQ-010 SHALL have the OBI response ports obi_rvalid_i (in, 1), obi_rdata_i (in, 32) and obi_err_i (in, 1).
REQ-011 SHALL have busy_o (out, 1), high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ADDR, WDATA, REQ, WAIT, RSP and RDATA.
REQ-013 A byte SHALL be consumed only on a cycle where rx_valid_i and rx_ready_o are both high.
REQ-014 rx_ready_o SHALL be high only in IDLE, ADDR and WDATA.
REQ-015 IDLE behaviour:
- a consumed byte equal to CmdRead or CmdWrite latches the op and moves to ADDR;
- any other byte is dropped silently and the FSM stays in IDLE.
REQ-016 ADDR SHALL consume 4 bytes, LSB first, into the 32-bit address. After byte 4:
- write goes to WDATA;
- read goes to REQ.
REQ-017 WDATA SHALL consume 4 bytes, LSB first, into the write data, then go to REQ.
REQ-018 A 2-bit byte counter SHALL clear on entry to ADDR and to WDATA, and wrap from 3 to 0 on the state transition.
REQ-019 An inter-byte timer SHALL count cycles spent in ADDR or WDATA without a consumed byte, and SHALL clear on every consumed byte.
REQ-020 When the timer reaches TimeoutCycles, the FSM SHALL return to IDLE, discard the partial frame and send no response.
REQ-021 obi_req_o SHALL rise the cycle after the last frame byte is consumed.
REQ-022 obi_req_o SHALL stay high until the first cycle with obi_gnt_i high; that cycle is the handshake and the FSM moves to WAIT.
REQ-023 While obi_req_o is high, obi_addr_o, obi_we_o, obi_be_o and obi_wdata_o SHALL be stable.
REQ-024 obi_be_o SHALL be 4'hF and obi_addr_o[1:0] SHALL be forced to 2'b00.
REQ-025 obi_we_o SHALL be 1 for write ops and 0 for read ops.
REQ-026 The bridge SHALL keep at most one outstanding transaction.
REQ-027 obi_rvalid_i SHALL be ignored outside WAIT.
REQ-028 When obi_rvalid_i is high in WAIT, the bridge SHALL latch obi_rdata_i and obi_err_i and move to RSP; obi_rvalid_i in the same cycle as obi_gnt_i is not legal and is not required to be supported.
REQ-029 RSP SHALL present tx_valid_o = 1 the cycle after rvalid, with tx_data_o = RspNak if the latched error is set, else RspAck.
REQ-030 tx_valid_o and tx_data_o SHALL hold until tx_ready_i; a byte is sent on the cycle where both are high.
REQ-031 After the response byte is sent:
- read without error goes to RDATA;
- every other case goes to IDLE.
REQ-032 RDATA SHALL send the 4 latched read-data bytes LSB first, each under the REQ-030 handshake, then go to IDLE.
REQ-033 tx_valid_o SHALL be high only in RSP and RDATA.
REQ-034 No timeout SHALL apply in REQ, WAIT, RSP or RDATA; back-pressure may stall these states indefinitely.
REQ-035 A command byte that arrives while busy_o is high SHALL be held off by rx_ready_o = 0 and never dropped.

Reset
REQ-036 While rst_ni is low, every output SHALL be 0 (rx_ready_o, tx_valid_o, tx_data_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, busy_o), and the FSM, counters and latches SHALL clear to IDLE/0.
REQ-037 Reset asserted mid-frame or with a bus transaction outstanding SHALL abandon the frame immediately; any obi_rvalid_i received after reset SHALL be ignored.
REQ-038 On the first rising edge after reset release, the FSM SHALL be in IDLE with rx_ready_o = 1.

Verification
REQ-039 Write frame 12 | 00 00 00 10 | 78 56 34 12 -> one OBI write with addr 0x1000_0000, wdata 0x1234_5678, be F, then TX byte 06.
REQ-040 Read frame 11 | 00 00 00 10 against a slave that returns 0x1234_5678, with gnt delayed 3 cycles and tx_ready_i low for 5 cycles -> TX bytes 06 78 56 34 12, request fields stable throughout.
REQ-041 Bytes 55 then 11 00 00 00 10 -> 55 dropped and the read proceeds normally.
REQ-042 Bytes 12 00 00, then 1024 idle cycles -> FSM back in IDLE with no OBI request and no TX byte; a following valid frame succeeds.
REQ-043 Read to a slave returning obi_err_i = 1 -> TX byte 15 only and no data bytes.
REQ-044 rst_ni pulsed low while in WAIT, then a late rvalid -> outputs 0 during reset and no TX traffic after release.

Source files
------------

// File: rtl/uart_dbg_bridge_if.sv
// uart_dbg_bridge_if: UART byte streams, OBI manager bus and busy flag of the debug bridge.
interface uart_dbg_bridge_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic        busy_o;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        output rx_ready_o, tx_valid_o, tx_data_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o,
               obi_wdata_o, busy_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  rx_ready_o, tx_valid_o, tx_data_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o,
               obi_wdata_o, busy_o
    );
endinterface

// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: turns UART command frames (cmd, addr, [wdata]) into single OBI
// transactions and answers with an ACK/NAK byte plus read data.
module uart_dbg_bridge #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [7:0]  CmdRead       = 8'h11,
    parameter logic [7:0]  CmdWrite      = 8'h12,
    parameter logic [7:0]  RspAck        = 8'h06,
    parameter logic [7:0]  RspNak        = 8'h15
) (
    input logic               clk_i,
    input logic               rst_ni,
    uart_dbg_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, WAIT, RSP, RDATA} state_t;

    localparam int unsigned    TW    = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0]  TLast = TW'(TimeoutCycles - 1);

    state_t        state;
    logic          op_write;
    logic          err;
    logic [1:0]    cnt;
    logic [1:0]    cnt_nx;
    logic [TW-1:0] timer;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          take;

    assign take            = bus.rx_valid_i && bus.rx_ready_o;
    assign cnt_nx          = cnt + 2'd1;
    assign bus.busy_o      = state != IDLE;
    assign bus.obi_addr_o  = addr & ~32'h3;
    assign bus.obi_we_o    = op_write;
    assign bus.obi_be_o    = {4{bus.obi_req_o}};
    assign bus.obi_wdata_o = wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            err            <= 1'b0;
            cnt            <= 2'd0;
            timer          <= '0;
            addr           <= '0;
            wdata          <= '0;
            rdata          <= '0;
            bus.rx_ready_o <= 1'b0;
            bus.tx_valid_o <= 1'b0;
            bus.tx_data_o  <= '0;
            bus.obi_req_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rx_ready_o <= 1'b1;
                    if (take && (bus.rx_data_i == CmdRead || bus.rx_data_i == CmdWrite)) begin
                        op_write <= bus.rx_data_i == CmdWrite;
                        cnt      <= 2'd0;
                        timer    <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR, WDATA: begin
                    if (take) begin
                        timer <= '0;
                        cnt   <= cnt_nx;
                        if (state == ADDR) addr[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
                        else wdata[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
                        if (cnt == 2'd3) begin
                            if (state == ADDR && op_write) state <= WDATA;
                            else begin
                                state          <= REQ;
                                bus.rx_ready_o <= 1'b0;
                                bus.obi_req_o  <= 1'b1;
                            end
                        end
                    end else if (timer == TLast) begin
                        // Stalled frame: drop it silently, no response is owed
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REQ: begin
                    if (bus.obi_gnt_i) begin
                        bus.obi_req_o <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.obi_rvalid_i) begin
                        rdata          <= bus.obi_rdata_i;
                        err            <= bus.obi_err_i;
                        bus.tx_valid_o <= 1'b1;
                        bus.tx_data_o  <= bus.obi_err_i ? RspNak : RspAck;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (bus.tx_ready_i) begin
                        if (!op_write && !err) begin
                            bus.tx_data_o <= rdata[7:0];
                            cnt           <= 2'd0;
                            state         <= RDATA;
                        end else begin
                            bus.tx_valid_o <= 1'b0;
                            bus.tx_data_o  <= '0;
                            bus.rx_ready_o <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                RDATA: begin
                    if (bus.tx_ready_i) begin
                        cnt <= cnt_nx;
                        if (cnt == 2'd3) begin
                            bus.tx_valid_o <= 1'b0;
                            bus.tx_data_o  <= '0;
                            bus.rx_ready_o <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            bus.tx_data_o <= rdata[{cnt_nx, 3'b000} +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed frames against uart_dbg_bridge with hand-computed expectations.
module tb_uart_dbg_bridge;
    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_bad;

    uart_dbg_bridge_if bus ();

    uart_dbg_bridge dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        while (!bus.rx_ready_o && n < 100) begin
            tick();
            n++;
        end
        chk("rx_accept", 32'(bus.rx_ready_o), 32'h1);
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic recv(input string tag, input logic [7:0] b);
        int n = 0;
        bus.tx_ready_i = 1'b1;
        while (!bus.tx_valid_o && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'({bus.tx_valid_o, bus.tx_data_o}), 32'({1'b1, b}));
        tick();
        bus.tx_ready_i = 1'b0;
    endtask

    task automatic obi_xfer(input logic [31:0] rd, input logic e);
        bus.obi_gnt_i = 1'b1;
        tick();
        bus.obi_gnt_i = 1'b0;
        chk("req_drop", 32'({bus.obi_req_o, bus.busy_o}), 32'b01);
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = rd;
        bus.obi_err_i    = e;
        tick();
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.rx_ready_o, bus.tx_valid_o, bus.obi_req_o, bus.obi_we_o,
                               bus.busy_o, bus.obi_be_o}), 32'h0);
        chk({tag, "_addr"}, bus.obi_addr_o, 32'h0);
        chk({tag, "_wdata"}, bus.obi_wdata_o, 32'h0);
        chk({tag, "_txdata"}, 32'(bus.tx_data_o), 32'h0);
    endtask

    initial begin
        bus.rx_valid_i   = 1'b0;
        bus.rx_data_i    = 8'h00;
        bus.tx_ready_i   = 1'b0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = 32'h0;
        bus.obi_err_i    = 1'b0;
        #2 rst_ni = 1'b0;
        #1 chk_zero("reset");
        tick();
        tick();
        chk_zero("reset_held");
        @(negedge clk) rst_ni = 1'b1;
        tick();
        chk("first_edge", 32'({bus.rx_ready_o, bus.busy_o}), 32'b10);

        // Write frame
        send(8'h12);
        chk("busy_addr", 32'(bus.busy_o), 32'h1);
        send4(32'h1000_0000);
        chk("wr_no_req_yet", 32'(bus.obi_req_o), 32'h0);
        send4(32'h1234_5678);
        chk("wr_req", 32'({bus.obi_req_o, bus.obi_we_o, bus.obi_be_o, bus.rx_ready_o}), 32'b1_1_1111_0);
        chk("wr_addr", bus.obi_addr_o, 32'h1000_0000);
        chk("wr_wdata", bus.obi_wdata_o, 32'h1234_5678);
        obi_xfer(32'h0, 1'b0);
        recv("wr_ack", 8'h06);
        chk("wr_done", 32'({bus.busy_o, bus.tx_valid_o, bus.rx_ready_o}), 32'b001);

        // Read with delayed grant and TX back-pressure
        send(8'h11);
        send4(32'h1000_0000);
        chk("rd_req", 32'({bus.obi_req_o, bus.obi_we_o, bus.obi_be_o}), 32'b1_0_1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_req_hold", 32'({bus.obi_req_o, bus.obi_we_o, bus.obi_be_o, bus.rx_ready_o}),
                32'b1_0_1111_0);
            chk("rd_addr_hold", bus.obi_addr_o, 32'h1000_0000);
        end
        obi_xfer(32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_tx_hold", 32'({bus.tx_valid_o, bus.tx_data_o, bus.rx_ready_o}),
                32'({1'b1, 8'h06, 1'b0}));
            tick();
        end
        recv("rd_ack", 8'h06);
        recv("rd_b0", 8'h78);
        recv("rd_b1", 8'h56);
        recv("rd_b2", 8'h34);
        recv("rd_b3", 8'h12);
        chk("rd_done", 32'({bus.busy_o, bus.tx_valid_o}), 32'b00);

        // Junk byte dropped, then a read
        send(8'h55);
        chk("junk_dropped", 32'({bus.busy_o, bus.rx_ready_o}), 32'b01);
        send(8'h11);
        send4(32'h1000_0000);
        obi_xfer(32'hA1B2_C3D4, 1'b0);
        recv("rd2_ack", 8'h06);
        recv("rd2_b0", 8'hD4);
        recv("rd2_b1", 8'hC3);
        recv("rd2_b2", 8'hB2);
        recv("rd2_b3", 8'hA1);

        // Inter-byte timeout
        send(8'h12);
        send(8'h00);
        send(8'h00);
        n_bad = 0;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (bus.obi_req_o || bus.tx_valid_o) n_bad++;
            if (i == 1023) chk("to_still_busy", 32'(bus.busy_o), 32'h1);
            if (i == 1024) chk("to_idle", 32'({bus.busy_o, bus.rx_ready_o}), 32'b01);
        end
        chk("to_no_traffic", 32'(n_bad), 32'h0);
        send(8'h12);
        send4(32'h2000_0007);
        send4(32'hCAFE_F00D);
        chk("to_next_addr", bus.obi_addr_o, 32'h2000_0004);
        chk("to_next_wdata", bus.obi_wdata_o, 32'hCAFE_F00D);
        obi_xfer(32'h0, 1'b0);
        recv("to_next_ack", 8'h06);

        // Bus error on read
        send(8'h11);
        send4(32'h3000_0000);
        obi_xfer(32'hDEAD_BEEF, 1'b1);
        recv("err_nak", 8'h15);
        bus.tx_ready_i = 1'b1;
        tick();
        tick();
        chk("err_no_data", 32'({bus.tx_valid_o, bus.busy_o}), 32'b00);
        bus.tx_ready_i = 1'b0;

        // Reset while waiting for the response
        send(8'h11);
        send4(32'h4000_0000);
        bus.obi_gnt_i = 1'b1;
        tick();
        bus.obi_gnt_i = 1'b0;
        chk("wait_busy", 32'({bus.busy_o, bus.obi_req_o}), 32'b10);
        rst_ni = 1'b0;
        #2 chk_zero("mid_reset");
        @(negedge clk) rst_ni = 1'b1;
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = 32'h5555_AAAA;
        bus.tx_ready_i   = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.tx_valid_o || bus.busy_o) n_bad++;
        end
        bus.obi_rvalid_i = 1'b0;
        chk("late_rvalid_ignored", 32'(n_bad), 32'h0);
        chk("post_reset_ready", 32'(bus.rx_ready_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
